shift_loader: RTL and testbench

- Sequencer that drives the external 6-bit serial-in shift register. The register shifts on each sr_clk rising edge and has an active-low async clear.
- Accepts a parallel word through a valid/ready handshake and serializes it MSB first onto sr_data with a generated, divided sr_clk.
- After the last bit, pulses sr_latch to transfer the word to the LED outputs.
- Also provides an on-demand clear pulse on sr_rst_n.
- Sits between the POV column scheduler and the board-level shift register pins.

---
 rtl/shift_loader.sv | 156 +++++++++++++++
 tb/tb_shift_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_loader.sv
// Sequencer for an external serial-in shift register: serializes a parallel word MSB first with a
// divided shift clock, then strobes the output latch. Also issues on-demand clear pulses.
module shift_loader #(
  parameter int unsigned NBITS = 6,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic             done,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch,
  output logic             sr_rst_n
);

  localparam int unsigned     BitW      = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [7:0]      PhaseLast = 8'(DIV - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(NBITS - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLatch, StClear} state_e;

  state_e           state_q, state_d;
  logic [7:0]       phase_q, phase_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             sr_clk_q, sr_clk_d;
  logic             sr_data_q, sr_data_d;
  logic             sr_latch_q, sr_latch_d;
  logic             sr_rst_n_q, sr_rst_n_d;
  logic             phase_end;

  assign phase_end = (phase_q == PhaseLast);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    sreg_d     = sreg_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    sr_clk_d   = sr_clk_q;
    sr_data_d  = sr_data_q;
    sr_latch_d = sr_latch_q;
    sr_rst_n_d = sr_rst_n_q;

    unique case (state_q)
      StIdle: begin
        // Releases the external clear and raises ready on the first edge out of reset.
        sr_rst_n_d = 1'b1;
        in_ready_d = 1'b1;
        phase_d    = '0;
        if (in_ready_q && clr) begin
          in_ready_d = 1'b0;
          sr_rst_n_d = 1'b0;
          state_d    = StClear;
        end else if (in_ready_q && in_valid) begin
          sreg_d     = in_data;
          sr_data_d  = in_data[NBITS-1];
          in_ready_d = 1'b0;
          bit_d      = '0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (phase_end) begin
          phase_d  = '0;
          sr_clk_d = 1'b1;
          state_d  = StHigh;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          phase_d  = '0;
          sr_clk_d = 1'b0;
          if (bit_q != BitLast) begin
            bit_d     = bit_q + 1'b1;
            sreg_d    = sreg_q << 1;
            sr_data_d = sreg_q[NBITS-2];
            state_d   = StSetup;
          end else begin
            sr_data_d  = 1'b0;
            sr_latch_d = 1'b1;
            state_d    = StLatch;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StLatch: begin
        if (phase_end) begin
          phase_d    = '0;
          sr_latch_d = 1'b0;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = StIdle;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StClear: begin
        if (phase_end) begin
          phase_d    = '0;
          sr_rst_n_d = 1'b1;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = StIdle;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_latch_q <= 1'b0;
      sr_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      sreg_q     <= sreg_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      sr_clk_q   <= sr_clk_d;
      sr_data_q  <= sr_data_d;
      sr_latch_q <= sr_latch_d;
      sr_rst_n_q <= sr_rst_n_d;
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign sr_clk   = sr_clk_q;
  assign sr_data  = sr_data_q;
  assign sr_latch = sr_latch_q;
  assign sr_rst_n = sr_rst_n_q;

endmodule

// File: tb/tb_shift_loader.sv
// Bench for shift_loader: one DIV=2 and one DIV=1 instance, each driving a model of the external
// 6-bit register and output latch; latched words are scoreboarded against the words sent.
module tb_shift_loader;
  localparam int unsigned N    = 6;
  localparam int unsigned ADIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] a_in_data, b_in_data;
  logic a_in_valid, a_clr, b_in_valid, b_clr;
  logic a_in_ready, a_done, a_sr_clk, a_sr_data, a_sr_latch, a_sr_rst_n;
  logic b_in_ready, b_done, b_sr_clk, b_sr_data, b_sr_latch, b_sr_rst_n;

  shift_loader #(.NBITS(N), .DIV(ADIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .clr(a_clr), .done(a_done), .sr_clk(a_sr_clk),
    .sr_data(a_sr_data), .sr_latch(a_sr_latch), .sr_rst_n(a_sr_rst_n)
  );

  shift_loader #(.NBITS(N), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .clr(b_clr), .done(b_done), .sr_clk(b_sr_clk),
    .sr_data(b_sr_data), .sr_latch(b_sr_latch), .sr_rst_n(b_sr_rst_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // External register and latch models
  logic [N-1:0] a_q = '0, a_led = '0, b_q = '0, b_led = '0;
  int a_rises = 0, b_rises = 0, a_clears = 0;
  logic [N-1:0] a_exp_q[$];
  logic [N-1:0] b_exp_q[$];

  always @(posedge a_sr_clk or negedge a_sr_rst_n)
    if (!a_sr_rst_n) a_q <= '0;
    else a_q <= {a_q[N-2:0], a_sr_data};
  always @(posedge b_sr_clk or negedge b_sr_rst_n)
    if (!b_sr_rst_n) b_q <= '0;
    else b_q <= {b_q[N-2:0], b_sr_data};
  always @(posedge a_sr_clk) a_rises++;
  always @(posedge b_sr_clk) b_rises++;
  always @(negedge a_sr_rst_n) a_clears++;

  always @(posedge a_sr_latch) begin
    a_led <= a_q;
    chk("a_sb_nonempty", 32'(a_exp_q.size() != 0), 1);
    if (a_exp_q.size() != 0) chk("a_latch_q", 32'(a_q), 32'(a_exp_q.pop_front()));
  end
  always @(posedge b_sr_latch) begin
    b_led <= b_q;
    chk("b_sb_nonempty", 32'(b_exp_q.size() != 0), 1);
    if (b_exp_q.size() != 0) chk("b_latch_q", 32'(b_q), 32'(b_exp_q.pop_front()));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (a_done !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, 32'(a_done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] w;
    int r0;
    int n;
    logic prev_clk, prev_data;

    a_in_data = '0; a_in_valid = 1'b0; a_clr = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_clr = 1'b0;

    // Reset then idle
    repeat (3) cyc();
    chk("rst_sr_rst_n", 32'(a_sr_rst_n), 0);
    chk("rst_in_ready", 32'(a_in_ready), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_sr_clk", 32'(a_sr_clk), 0);
    chk("rst_sr_data", 32'(a_sr_data), 0);
    chk("rst_sr_latch", 32'(a_sr_latch), 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_sr_rst_n", 32'(a_sr_rst_n), 1);
    chk("rel_in_ready", 32'(a_in_ready), 1);
    chk("rel_b_in_ready", 32'(b_in_ready), 1);

    // Single load, DIV=2, cycle-exact waveform
    w = 6'b101101;
    a_in_data = w; a_in_valid = 1'b1; a_exp_q.push_back(w);
    r0 = a_rises;
    cyc();
    a_in_valid = 1'b0;
    chk("load_accept_ready", 32'(a_in_ready), 0);
    prev_clk = a_sr_clk; prev_data = a_sr_data;
    for (int c = 1; c <= int'((2 * N + 1) * ADIV); c++) begin
      int unsigned ph;
      logic e_clk;
      cyc();
      ph = c / ADIV;
      e_clk = (c < int'(2 * N * ADIV)) && (ph % 2 == 1);
      chk($sformatf("load_sr_clk_c%0d", c), 32'(a_sr_clk), 32'(e_clk));
      chk($sformatf("load_latch_c%0d", c), 32'(a_sr_latch),
          32'(c >= int'(2 * N * ADIV) && c < int'((2 * N + 1) * ADIV)));
      chk($sformatf("load_done_c%0d", c), 32'(a_done), 32'(c == int'((2 * N + 1) * ADIV)));
      if (c % ADIV == 0 && e_clk) begin
        chk($sformatf("load_bit_c%0d", c), 32'(a_sr_data), 32'(w[N - 1 - (ph - 1) / 2]));
      end
      if (!prev_clk && a_sr_clk) chk($sformatf("load_data_stable_c%0d", c), 32'(a_sr_data),
                                     32'(prev_data));
      prev_clk = a_sr_clk; prev_data = a_sr_data;
    end
    chk("load_in_ready", 32'(a_in_ready), 1);
    chk("load_rises", 32'(a_rises - r0), 6);
    chk("load_led", 32'(a_led), 32'(w));

    // Clear priority over in_valid
    r0 = a_rises;
    a_clr = 1'b1; a_in_valid = 1'b1; a_in_data = 6'h15;
    cyc();
    a_clr = 1'b0;
    chk("clr_rst_n_c0", 32'(a_sr_rst_n), 0);
    chk("clr_in_ready_c0", 32'(a_in_ready), 0);
    chk("clr_model_q", 32'(a_q), 0);
    cyc();
    chk("clr_rst_n_c1", 32'(a_sr_rst_n), 0);
    chk("clr_done_c1", 32'(a_done), 0);
    a_exp_q.push_back(6'h15);
    cyc();
    chk("clr_rst_n_c2", 32'(a_sr_rst_n), 1);
    chk("clr_done_c2", 32'(a_done), 1);
    chk("clr_in_ready_c2", 32'(a_in_ready), 1);
    chk("clr_no_sr_clk", 32'(a_rises - r0), 0);
    cyc();
    a_in_valid = 1'b0;
    chk("clr_then_accept", 32'(a_in_ready), 0);
    wait_done_a("clr_load_done");
    chk("clr_load_led", 32'(a_led), 32'h15);

    // Ignored inputs while busy
    n = a_clears;
    a_in_data = 6'h2A; a_in_valid = 1'b1; a_exp_q.push_back(6'h2A);
    cyc();
    for (int c = 1; c <= int'((2 * N + 1) * ADIV); c++) begin
      a_in_data = N'($urandom);
      a_clr = (c == 5 || c == 20);
      a_in_valid = c[0];
      cyc();
    end
    a_clr = 1'b0; a_in_valid = 1'b0;
    chk("ign_done", 32'(a_done), 1);
    chk("ign_no_clear", 32'(a_clears - n), 0);
    chk("ign_led", 32'(a_led), 32'h2A);

    // Reset mid-load: no latch expected, nothing pushed
    r0 = a_rises;
    a_in_data = 6'h33; a_in_valid = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    n = 0;
    while (a_rises - r0 < 3 && n < 100) begin
      cyc();
      n++;
    end
    chk("mid_third_rise", 32'(a_rises - r0), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_sr_clk", 32'(a_sr_clk), 0);
    chk("mid_sr_latch", 32'(a_sr_latch), 0);
    chk("mid_sr_data", 32'(a_sr_data), 0);
    chk("mid_sr_rst_n", 32'(a_sr_rst_n), 0);
    chk("mid_model_q", 32'(a_q), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_rel_in_ready", 32'(a_in_ready), 1);
    chk("mid_rel_sr_rst_n", 32'(a_sr_rst_n), 1);
    chk("mid_rel_q", 32'(a_q), 0);

    // Back-to-back, DIV=1
    r0 = b_rises;
    b_in_data = 6'h3F; b_in_valid = 1'b1; b_exp_q.push_back(6'h3F);
    cyc();
    for (int c = 1; c <= 2 * N + 1; c++) begin
      cyc();
      chk($sformatf("b2b_ready_c%0d", c), 32'(b_in_ready), 32'(c == 2 * N + 1));
    end
    b_in_data = 6'h00; b_exp_q.push_back(6'h00);
    cyc();
    b_in_valid = 1'b0;
    chk("b2b_second_accept", 32'(b_in_ready), 0);
    chk("b2b_led_first", 32'(b_led), 32'h3F);
    for (int c = 1; c <= 2 * N + 1; c++) begin
      cyc();
      chk($sformatf("b2b2_done_c%0d", c), 32'(b_done), 32'(c == 2 * N + 1));
    end
    chk("b2b_rises", 32'(b_rises - r0), 12);
    chk("b2b_led_second", 32'(b_led), 0);

    chk("a_sb_drain", 32'(a_exp_q.size()), 0);
    chk("b_sb_drain", 32'(b_exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
